maxnet_input_loader: RTL and testbench

//   Upstream feeder for the maxnet core. Collects N candidate activations
//   (IEEE-754 single, 32-bit) one per cycle over a valid/ready stream and

---
 rtl/maxnet_input_loader_if.sv | 32 +++
 rtl/maxnet_input_loader.sv | 122 ++++++++++++
 tb/tb_maxnet_input_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/maxnet_input_loader_if.sv
// ---------------------------------------------------------------------------
// maxnet_input_loader_if
//   Valid/ready sample stream that feeds the maxnet input loader.
//   Parameter:
//     W         sample width in bits (IEEE-754 single by default)
//   Signals:
//     in_valid  producer has a sample on in_data
//     in_data   sample value
//     in_ready  consumer accepts the sample on this cycle
//   Modports:
//     master    upstream producer (drives valid/data, observes ready)
//     slave     the loader (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface maxnet_input_loader_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/maxnet_input_loader.sv
// ---------------------------------------------------------------------------
// maxnet_input_loader
//   Upstream feeder for the maxnet core. Collects N candidate activations,
//   one per cycle, from a valid/ready stream into a register bank that is
//   presented in parallel on x_flat. Once the bank is full it pulses start
//   for one cycle, freezes x_flat while maxnet works, and reopens for the
//   next batch when maxnet reports mx_done.
//
//   Parameters:
//     N          candidates per batch (>= 2)
//     W          candidate width in bits
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-low reset
//     stream     sample stream (slave side: in_valid, in_data, in_ready)
//     x_flat     slot i on bits [i*W +: W]
//     start      one-cycle start pulse to maxnet
//     mx_done    maxnet done (level or pulse), honoured only while waiting
//     busy       batch handed off, waiting for mx_done
//     fill_cnt   slots filled in the current batch (reads N once full)
//     batch_cnt  completed batches, wraps 16'hFFFF -> 0
//
//   Build option:
//     MAXNET_LOADER_CLAMP_EN  when defined, samples with the sign bit set
//                             are stored as +0.0 because maxnet needs
//                             non-negative activations; otherwise samples
//                             are stored bit-exact.
// ---------------------------------------------------------------------------
module maxnet_input_loader #(
    parameter  int N  = 4,
    parameter  int W  = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    maxnet_input_loader_if.slave  stream,
    output logic [N*W-1:0]        x_flat,
    output logic                  start,
    input  logic                  mx_done,
    output logic                  busy,
    output logic [CW-1:0]         fill_cnt,
    output logic [15:0]           batch_cnt
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t       state;
    logic         ready_q;
    logic [W-1:0] sample;

    // Value actually written into a slot.
`ifdef MAXNET_LOADER_CLAMP_EN
    assign sample = stream.in_data[W-1] ? '0 : stream.in_data;
`else
    assign sample = stream.in_data;
`endif

    assign stream.in_ready = ready_q;

    // Single FSM block. in_ready, start and busy are registered alongside
    // the state so they track the state register only and never depend
    // combinationally on in_valid or mx_done. ready_q resets high so the
    // loader is ready as soon as rst is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FILL;
            ready_q   <= 1'b1;
            start     <= 1'b0;
            busy      <= 1'b0;
            x_flat    <= '0;
            fill_cnt  <= '0;
            batch_cnt <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (stream.in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            if (fill_cnt == CW'(i)) begin
                                x_flat[i*W +: W] <= sample;
                            end
                        end
                        fill_cnt <= fill_cnt + 1'b1;
                        // Last slot written: hand the bank to maxnet.
                        if (fill_cnt == CW'(N - 1)) begin
                            state   <= S_FIRE;
                            ready_q <= 1'b0;
                            start   <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end

                S_FIRE: begin
                    state <= S_WAIT;
                    start <= 1'b0;
                end

                S_WAIT: begin
                    if (mx_done) begin
                        state     <= S_FILL;
                        ready_q   <= 1'b1;
                        busy      <= 1'b0;
                        fill_cnt  <= '0;
                        batch_cnt <= batch_cnt + 16'd1;
                    end
                end

                default: begin
                    state   <= S_FILL;
                    ready_q <= 1'b1;
                    start   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// ---------------------------------------------------------------------------
// tb_maxnet_input_loader
//   Directed testbench for maxnet_input_loader (N=4, W=32). Inputs are
//   driven and outputs observed on the falling clock edge, so every
//   observation reflects the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_maxnet_input_loader;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = $clog2(N + 1);

    logic           clk;
    logic           rst;
    logic [N*W-1:0] x_flat;
    logic           start;
    logic           mx_done;
    logic           busy;
    logic [CW-1:0]  fill_cnt;
    logic [15:0]    batch_cnt;

    int checksTotal;
    int checksPassed;
    int startCount;

    logic [N*W-1:0] expFlat;
    logic [W-1:0]   expClamp;

    maxnet_input_loader_if #(.W(W)) stream ();

    maxnet_input_loader #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (stream.slave),
        .x_flat    (x_flat),
        .start     (start),
        .mx_done   (mx_done),
        .busy      (busy),
        .fill_cnt  (fill_cnt),
        .batch_cnt (batch_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then wait for the next falling edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                                 input logic done);
        stream.in_valid = v;
        stream.in_data  = d;
        mx_done         = done;
        @(negedge clk);
        if (start) startCount++;
    endtask

    initial begin
        checksTotal     = 0;
        checksPassed    = 0;
        startCount      = 0;
        rst             = 1'b0;
        stream.in_valid = 1'b0;
        stream.in_data  = '0;
        mx_done         = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_x_flat",    128'(x_flat),    128'h0);
        checkOutput("rst_fill_cnt",  128'(fill_cnt),  128'h0);
        checkOutput("rst_batch_cnt", 128'(batch_cnt), 128'h0);
        checkOutput("rst_start",     128'(start),     128'h0);
        checkOutput("rst_busy",      128'(busy),      128'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready",  128'(stream.in_ready), 128'h1);

        // mx_done while filling is ignored.
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("fill_done_batch", 128'(batch_cnt), 128'h0);
        checkOutput("fill_done_ready", 128'(stream.in_ready), 128'h1);
        checkOutput("fill_done_busy",  128'(busy), 128'h0);

        // Back-to-back batch of four samples.
        startCount = 0;
        applyStimulus(1'b1, 32'h3F800000, 1'b0);
        applyStimulus(1'b1, 32'h40000000, 1'b0);
        applyStimulus(1'b1, 32'h40400000, 1'b0);
        checkOutput("b1_fill_3",    128'(fill_cnt), 128'd3);
        checkOutput("b1_no_start",  128'(start), 128'h0);
        applyStimulus(1'b1, 32'h40800000, 1'b0);
        expFlat = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        checkOutput("b1_x_flat",    128'(x_flat), 128'(expFlat));
        checkOutput("b1_start",     128'(start), 128'h1);
        checkOutput("b1_busy",      128'(busy), 128'h1);
        checkOutput("b1_ready",     128'(stream.in_ready), 128'h0);
        checkOutput("b1_fill_4",    128'(fill_cnt), 128'd4);

        // Valid held with new data while handed off; mx_done in FIRE ignored.
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
        checkOutput("fire_done_start", 128'(start), 128'h0);
        checkOutput("fire_done_busy",  128'(busy), 128'h1);
        checkOutput("fire_done_batch", 128'(batch_cnt), 128'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hCAFE0000 + i, 1'b0);
        checkOutput("wait_x_flat",  128'(x_flat), 128'(expFlat));
        checkOutput("wait_fill",    128'(fill_cnt), 128'd4);
        checkOutput("wait_ready",   128'(stream.in_ready), 128'h0);
        checkOutput("b1_start_cnt", 128'(startCount), 128'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("done_batch",   128'(batch_cnt), 128'd1);
        checkOutput("done_fill",    128'(fill_cnt), 128'd0);
        checkOutput("done_ready",   128'(stream.in_ready), 128'h1);
        checkOutput("done_busy",    128'(busy), 128'h0);

        // Gapped input: valid toggles every cycle.
        startCount = 0;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, 32'h41000000 + 32'(i), 1'b0);
            else            applyStimulus(1'b0, 32'h0BAD0000 + 32'(i), 1'b0);
        end
        expFlat = {32'h41000006, 32'h41000004, 32'h41000002, 32'h41000000};
        checkOutput("gap_x_flat",   128'(x_flat), 128'(expFlat));
        checkOutput("gap_start",    128'(start), 128'h1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("gap_start_cnt", 128'(startCount), 128'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("gap_batch",    128'(batch_cnt), 128'd2);
        mx_done = 1'b0;

        // Reset after two samples of a batch.
        startCount = 0;
        applyStimulus(1'b1, 32'h42000000, 1'b0);
        applyStimulus(1'b1, 32'h42000001, 1'b0);
        stream.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_fill",  128'(fill_cnt), 128'h0);
        checkOutput("mid_rst_flat",  128'(x_flat), 128'h0);
        checkOutput("mid_rst_batch", 128'(batch_cnt), 128'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("mid_rst_no_start", 128'(startCount), 128'd0);
        applyStimulus(1'b1, 32'h43000000, 1'b0);
        applyStimulus(1'b1, 32'h43000001, 1'b0);
        applyStimulus(1'b1, 32'h43000002, 1'b0);
        applyStimulus(1'b1, 32'h43000003, 1'b0);
        expFlat = {32'h43000003, 32'h43000002, 32'h43000001, 32'h43000000};
        checkOutput("post_rst_flat",  128'(x_flat), 128'(expFlat));
        checkOutput("post_rst_start", 128'(start), 128'h1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // batch_cnt wrap: preload FFFF while waiting, then complete.
        force dut.batch_cnt = 16'hFFFF;
        #1;
        release dut.batch_cnt;
        checkOutput("wrap_pre",  128'(batch_cnt), 128'hFFFF);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_post", 128'(batch_cnt), 128'h0);

        // Negative sample: clamped or bit-exact; other slots keep old data.
`ifdef MAXNET_LOADER_CLAMP_EN
        expClamp = 32'h00000000;
`else
        expClamp = 32'hBF800000;
`endif
        applyStimulus(1'b1, 32'hBF800000, 1'b0);
        expFlat = {32'h43000003, 32'h43000002, 32'h43000001, expClamp};
        checkOutput("neg_sample", 128'(x_flat), 128'(expFlat));
        checkOutput("neg_fill",   128'(fill_cnt), 128'd1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
